loop_ram_scheduler: RTL and testbench

- Sequences all accesses to the shared pseudo-SRAM for two-track loop recording and playback.
- On each audio sample tick it performs the following memory cycles through a req/ack handshake to the async RAM controller, in order:
  - a read of track 0, if playing;
  - a read of track 1, if playing;
  - a write of the record sample, if recording.
- It then saturating-mixes the read samples into one output sample.
- Sits between the track controller/signal adder and the async RAM controller; its output feeds the pmod output stage.

---
 rtl/loop_ram_scheduler.sv | 250 +++++++++++++++++++++++++
 tb/tb_loop_ram_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_ram_scheduler.sv
// ---------------------------------------------------------------------------
// loop_ram_scheduler
//
// Sequences every access to the shared pseudo-SRAM for two-track loop
// recording and playback. On each sample_tick it reads track 0 and/or track 1
// (if playing), then writes the record sample (if recording), using a req/ack
// handshake to the async RAM controller. It then saturating-mixes the two read
// samples into mix_out and advances the loop position.
//
// Ports
//   clk          100 MHz system clock
//   rst_n        asynchronous active-low reset
//   sample_tick  one-cycle pulse per audio sample
//   rec_en       record the current sample this tick
//   rec_track    track index written when recording
//   play_mask    bit i set = track i plays back
//   rec_data     sample to record (two's complement)
//   mem_req      access request to RAM controller (held until ack inclusive)
//   mem_we       1 = write, 0 = read; valid while mem_req
//   mem_addr     {track, pos}; valid while mem_req
//   mem_wdata    write data; valid while mem_req
//   mem_ack      one-cycle completion pulse from RAM controller
//   mem_rdata    read data, valid in the mem_ack cycle
//   mix_out      mixed playback sample, held between updates
//   mix_valid    one-cycle pulse when mix_out updates
//   overrun      one-cycle pulse when sample_tick arrives while busy
//   pos          current loop position
//
// State table
//   state  | meaning
//   IDLE   | waiting for sample_tick; latches the per-tick controls
//   RD0    | reading track 0 at {0,pos}
//   RD1    | reading track 1 at {1,pos}
//   WR     | writing rec_data at {rec_track,pos}
//   MIX    | saturating mix of s0+s1, pos update, back to IDLE
// ---------------------------------------------------------------------------
module loop_ram_scheduler #(
  parameter int POS_W  = 22,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic              rec_en,
  input  logic              rec_track,
  input  logic [1:0]        play_mask,
  input  logic [DATA_W-1:0] rec_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [POS_W:0]    mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mix_out,
  output logic              mix_valid,
  output logic              overrun,
  output logic [POS_W-1:0]  pos
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_WR   = 3'd3,
    S_MIX  = 3'd4
  } state_t;

  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t              state_q, state_d;
  logic [1:0]          mask_q, mask_d;
  logic                rec_en_q, rec_en_d;
  logic                rec_track_q, rec_track_d;
  logic [DATA_W-1:0]   rec_data_q, rec_data_d;
  logic [DATA_W-1:0]   s0_q, s0_d;
  logic [DATA_W-1:0]   s1_q, s1_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [POS_W:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   mix_out_q, mix_out_d;
  logic                mix_valid_q, mix_valid_d;
  logic                overrun_q, overrun_d;

  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   sat_val;
  logic                acc_track;

  // Next needed state in the fixed order RD0, RD1, WR, MIX, skipping any
  // access the latched controls do not ask for.
  function automatic state_t next_access(input state_t from,
                                         input logic [1:0] mask,
                                         input logic rec);
    state_t nxt;
    nxt = S_MIX;
    case (from)
      S_IDLE: begin
        if (mask[0])      nxt = S_RD0;
        else if (mask[1]) nxt = S_RD1;
        else if (rec)     nxt = S_WR;
        else              nxt = S_MIX;
      end
      S_RD0: begin
        if (mask[1])      nxt = S_RD1;
        else if (rec)     nxt = S_WR;
        else              nxt = S_MIX;
      end
      S_RD1: begin
        if (rec)          nxt = S_WR;
        else              nxt = S_MIX;
      end
      default:            nxt = S_MIX;
    endcase
    return nxt;
  endfunction

  // One extra bit of headroom; overflow shows up as the two top bits differing.
  always_comb begin
    sum     = {s0_q[DATA_W-1], s0_q} + {s1_q[DATA_W-1], s1_q};
    sat_val = sum[DATA_W-1:0];
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      sat_val = sum[DATA_W] ? SAT_MIN : SAT_MAX;
    end
  end

  always_comb begin
    acc_track = 1'b0;
    case (state_q)
      S_RD1:   acc_track = 1'b1;
      S_WR:    acc_track = rec_track_q;
      default: acc_track = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    rec_en_d    = rec_en_q;
    rec_track_d = rec_track_q;
    rec_data_d  = rec_data_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    pos_d       = pos_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mix_out_d   = mix_out_q;
    mix_valid_d = 1'b0;
    overrun_d   = 1'b0;

    // A tick while anything is in flight (including the MIX cycle) is dropped.
    if (sample_tick && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          mask_d      = play_mask;
          rec_en_d    = rec_en;
          rec_track_d = rec_track;
          rec_data_d  = rec_data;
          s0_d        = '0;
          s1_d        = '0;
          state_d     = next_access(S_IDLE, play_mask, rec_en);
        end
      end

      S_RD0, S_RD1, S_WR: begin
        if (!mem_req_q) begin
          // Entry cycle: set up address/data so they are stable for the
          // whole request, which starts on the next cycle.
          mem_req_d   = 1'b1;
          mem_addr_d  = {acc_track, pos_q};
          mem_we_d    = (state_q == S_WR);
          mem_wdata_d = rec_data_q;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          if (state_q == S_RD0) s0_d = mem_rdata;
          if (state_q == S_RD1) s1_d = mem_rdata;
          state_d = next_access(state_q, mask_q, rec_en_q);
        end
      end

      S_MIX: begin
        mix_out_d   = sat_val;
        mix_valid_d = 1'b1;
        // An idle tick realigns the loop so the next take starts at 0.
        if ((mask_q != 2'b00) || rec_en_q) pos_d = pos_q + POS_ONE;
        else                               pos_d = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      rec_en_q    <= 1'b0;
      rec_track_q <= 1'b0;
      rec_data_q  <= '0;
      s0_q        <= '0;
      s1_q        <= '0;
      pos_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      rec_en_q    <= rec_en_d;
      rec_track_q <= rec_track_d;
      rec_data_q  <= rec_data_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      pos_q       <= pos_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign overrun   = overrun_q;
  assign pos       = pos_q;

endmodule

// File: tb/tb_loop_ram_scheduler.sv
// ---------------------------------------------------------------------------
// tb_loop_ram_scheduler
//
// Drives loop_ram_scheduler (POS_W=3) against a RAM responder with
// configurable ack delay, and compares every serviced tick against a
// transaction-level model: expected access list, mixed sample, loop position,
// latency, and mix_valid/overrun pulse counts.
// ---------------------------------------------------------------------------
module tb_loop_ram_scheduler;
  localparam int POS_W  = 3;
  localparam int DATA_W = 16;
  localparam int AW     = POS_W + 1;
  localparam int NWORDS = 1 << AW;
  localparam int TLEN   = 1 << POS_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_tick = 1'b0;
  logic              rec_en = 1'b0;
  logic              rec_track = 1'b0;
  logic [1:0]        play_mask = 2'b00;
  logic [DATA_W-1:0] rec_data = '0;
  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] mix_out;
  logic              mix_valid;
  logic              overrun;
  logic [POS_W-1:0]  pos;

  always #5 clk = ~clk;

  loop_ram_scheduler #(.POS_W(POS_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rec_en(rec_en),
    .rec_track(rec_track), .play_mask(play_mask), .rec_data(rec_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mix_out(mix_out), .mix_valid(mix_valid), .overrun(overrun), .pos(pos)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit we;
    int addr;
    int data;
  } acc_t;

  logic [DATA_W-1:0] ram     [NWORDS];
  logic [DATA_W-1:0] ref_ram [NWORDS];
  int   ref_pos = 0;
  acc_t acc_log[$];

  int dly_lo = 0;
  int dly_hi = 0;

  // RAM controller model: ack after a random number of extra cycles.
  bit            in_req = 0;
  int            wcnt = 0;
  logic [AW-1:0] a0;
  logic          w0;
  logic [DATA_W-1:0] d0;

  initial forever begin
    @(posedge clk); #1;
    mem_ack = 1'b0;
    if (mem_req !== 1'b1) begin
      in_req = 0;
    end else begin
      if (!in_req) begin
        in_req = 1;
        wcnt = $urandom_range(dly_hi, dly_lo);
        a0 = mem_addr; w0 = mem_we; d0 = mem_wdata;
      end
      if (wcnt == 0) begin
        acc_t e;
        chk_val("addr_stable", 32'(mem_addr), 32'(a0));
        chk_val("we_stable", 32'(mem_we), 32'(w0));
        if (w0) chk_val("wdata_stable", 32'(mem_wdata), 32'(d0));
        if (mem_we) ram[mem_addr] = mem_wdata;
        else        mem_rdata = ram[mem_addr];
        e.we   = mem_we;
        e.addr = int'(mem_addr);
        e.data = mem_we ? int'(mem_wdata) : int'(mem_rdata);
        acc_log.push_back(e);
        mem_ack = 1'b1;
        in_req = 0;
      end else begin
        wcnt--;
      end
    end
  end

  int mv_cnt = 0;
  int ov_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (mix_valid === 1'b1) mv_cnt++;
    if (overrun === 1'b1)   ov_cnt++;
  end

  task automatic preload(input int track, input logic [DATA_W-1:0] v);
    for (int p = 0; p < TLEN; p++) begin
      ram[track*TLEN + p]     = v;
      ref_ram[track*TLEN + p] = v;
    end
  endtask

  // One serviced tick: predict, drive, then compare.
  task automatic run_tick(input logic [1:0] m, input logic re, input logic rt,
                          input logic [DATA_W-1:0] rd, input bit ovr, input bit spur);
    acc_t exp_q[$];
    acc_t e;
    int   v0, v1, s, idx, exp_lat, lat, base_mv, base_ov;
    int   exp_pos;
    logic [DATA_W-1:0] exp_mix;
    bit   zw;
    zw = (dly_hi == 0);
    v0 = 0; v1 = 0; lat = -1;
    if (m[0]) begin
      idx = ref_pos;
      e.we = 0; e.addr = idx; e.data = int'(ref_ram[idx]);
      exp_q.push_back(e);
      v0 = int'($signed(ref_ram[idx]));
    end
    if (m[1]) begin
      idx = TLEN + ref_pos;
      e.we = 0; e.addr = idx; e.data = int'(ref_ram[idx]);
      exp_q.push_back(e);
      v1 = int'($signed(ref_ram[idx]));
    end
    if (re) begin
      idx = int'(rt) * TLEN + ref_pos;
      e.we = 1; e.addr = idx; e.data = int'(rd);
      exp_q.push_back(e);
      ref_ram[idx] = rd;
    end
    s = v0 + v1;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    exp_mix = DATA_W'(s);
    exp_lat = 2 * exp_q.size() + 2;
    exp_pos = ((m != 2'b00) || re) ? (ref_pos + 1) % TLEN : 0;
    ref_pos = exp_pos;

    acc_log.delete();
    base_mv = mv_cnt;
    base_ov = ov_cnt;

    @(posedge clk); #1;
    sample_tick = 1'b1; play_mask = m; rec_en = re; rec_track = rt; rec_data = rd;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Scramble live controls: the sequence must run on latched copies.
        sample_tick = ovr;
        play_mask = 2'($urandom); rec_en = 1'($urandom);
        rec_track = 1'($urandom); rec_data = 16'($urandom);
      end
      if (c == 2) sample_tick = 1'b0;
      if (mix_valid === 1'b1) begin lat = c; break; end
    end
    sample_tick = 1'b0;
    chk_val("mix_valid_seen", 32'(lat >= 0), 32'd1);
    if (zw) chk_val("latency", 32'(lat), 32'(exp_lat));
    chk_val("mix_out", 32'(mix_out), 32'(exp_mix));
    chk_val("pos", 32'(pos), 32'(exp_pos));
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk_val("mix_valid_pulses", 32'(mv_cnt - base_mv), 32'd1);
    chk_val("overrun_pulses", 32'(ov_cnt - base_ov), 32'(ovr));
    chk_val("access_count", 32'(acc_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < acc_log.size(); i++) begin
      chk_val("acc_we", 32'(acc_log[i].we), 32'(exp_q[i].we));
      chk_val("acc_addr", 32'(acc_log[i].addr), 32'(exp_q[i].addr));
      chk_val("acc_data", 32'(acc_log[i].data), 32'(exp_q[i].data));
    end
    if (spur) begin
      // Stray ack while idle must not disturb anything.
      @(negedge clk);
      mem_ack = 1'b1;
      mem_rdata = 16'($urandom);
      @(negedge clk);
    end
  endtask

  initial begin
    int found;
    for (int i = 0; i < NWORDS; i++) begin
      ram[i] = 16'($urandom);
      ref_ram[i] = ram[i];
    end

    // Reset values
    repeat (3) @(negedge clk);
    chk_val("rst_mem_req", 32'(mem_req), 32'd0);
    chk_val("rst_mix_out", 32'(mix_out), 32'd0);
    chk_val("rst_mix_valid", 32'(mix_valid), 32'd0);
    chk_val("rst_overrun", 32'(overrun), 32'd0);
    chk_val("rst_pos", 32'(pos), 32'd0);
    chk_val("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Record only on track 1, 9 ticks, ack 3 cycles late; pos wraps 7 -> 0
    dly_lo = 3; dly_hi = 3;
    for (int t = 0; t < 9; t++) run_tick(2'b00, 1'b1, 1'b1, 16'h1234, 0, 0);

    // Play both, positive and negative saturation, zero-wait acks
    dly_lo = 0; dly_hi = 0;
    preload(0, 16'h7000); preload(1, 16'h2000);
    run_tick(2'b11, 1'b0, 1'b0, 16'h0, 0, 0);
    run_tick(2'b11, 1'b0, 1'b0, 16'h0, 0, 1);
    preload(0, 16'h9000); preload(1, 16'hA000);
    run_tick(2'b11, 1'b0, 1'b0, 16'h0, 0, 0);
    run_tick(2'b11, 1'b0, 1'b0, 16'h0, 0, 0);

    // Overdub same track: read precedes write
    dly_lo = 0; dly_hi = 2;
    for (int t = 0; t < 4; t++) run_tick(2'b01, 1'b1, 1'b0, 16'($urandom), 0, 0);

    // Overrun while in RD0 awaiting ack
    dly_lo = 2; dly_hi = 4;
    run_tick(2'b01, 1'b0, 1'b0, 16'h0, 1, 0);
    dly_lo = 0; dly_hi = 0;
    run_tick(2'b11, 1'b1, 1'b1, 16'h5A5A, 1, 0);

    // Idle tick from a nonzero position resets pos
    run_tick(2'b00, 1'b0, 1'b0, 16'h0, 0, 0);
    run_tick(2'b00, 1'b0, 1'b0, 16'h0, 1, 0);

    // Reset in the middle of an RD1 request
    run_tick(2'b10, 1'b1, 1'b0, 16'h0BAD, 0, 0);
    dly_lo = 20; dly_hi = 20;
    @(posedge clk); #1;
    sample_tick = 1'b1; play_mask = 2'b11; rec_en = 1'b0;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    found = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_addr[POS_W] === 1'b1) begin found = 1; break; end
    end
    chk_val("rd1_reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_val("midrst_mem_req", 32'(mem_req), 32'd0);
    chk_val("midrst_mem_we", 32'(mem_we), 32'd0);
    chk_val("midrst_mem_addr", 32'(mem_addr), 32'd0);
    chk_val("midrst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk_val("midrst_mix_out", 32'(mix_out), 32'd0);
    chk_val("midrst_mix_valid", 32'(mix_valid), 32'd0);
    chk_val("midrst_overrun", 32'(overrun), 32'd0);
    chk_val("midrst_pos", 32'(pos), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ref_pos = 0;
    dly_lo = 0; dly_hi = 0;
    run_tick(2'b01, 1'b0, 1'b0, 16'h0, 0, 0);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      dly_lo = 0;
      dly_hi = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(3, 0));
      run_tick(2'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
               ($urandom_range(4, 0) == 0), ($urandom_range(5, 0) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
